// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and defaults for the RTC alarm scheduler
package rtc_pkg;

    localparam int RTC_NUM_SLOT  = 4;
    localparam int RTC_CNT_WIDTH = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } rtc_sched_state_e;

endpackage

// File: rtl/rtc_rr_arb.sv
// rtl/rtc_rr_arb.sv - combinational round-robin pick of the first request at or after ptr
module rtc_rr_arb #(
    parameter int NUM_SLOT  = 4,
    parameter int IDX_WIDTH = $clog2(NUM_SLOT)
) (
    input  logic [NUM_SLOT-1:0]  req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [IDX_WIDTH-1:0] grant_o,
    output logic                 any_o
);

    int idx;

    // Scan from the farthest offset down so the nearest request to ptr is the last one written.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = NUM_SLOT - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_SLOT) begin
                idx = idx - NUM_SLOT;
            end
            if (req_i[idx]) begin
                grant_o = IDX_WIDTH'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_alarm_sched.sv
// rtl/rtc_alarm_sched.sv - multi-slot alarm compare with round-robin valid/ready event port
module rtc_alarm_sched
    import rtc_pkg::*;
#(
    parameter int NUM_SLOT  = RTC_NUM_SLOT,
    parameter int CNT_WIDTH = RTC_CNT_WIDTH,
    parameter int IDX_WIDTH = $clog2(NUM_SLOT)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_vld_i,
    input  logic                 cfg_wr_i,
    input  logic [IDX_WIDTH-1:0] cfg_idx_i,
    input  logic                 cfg_en_i,
    input  logic [CNT_WIDTH-1:0] cfg_alarm_i,
    input  logic [CNT_WIDTH-1:0] cfg_period_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [IDX_WIDTH-1:0] evt_idx_o,
    output logic                 irq_o,
    output logic [NUM_SLOT-1:0]  en_o,
    output logic [NUM_SLOT-1:0]  pend_o,
    output logic [NUM_SLOT-1:0]  ovf_o
);

    logic [NUM_SLOT-1:0]  en_q, en_d;
    logic [NUM_SLOT-1:0]  pend_q, pend_d;
    logic [NUM_SLOT-1:0]  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] alarm_q [NUM_SLOT];
    logic [CNT_WIDTH-1:0] alarm_d [NUM_SLOT];
    logic [CNT_WIDTH-1:0] period_q [NUM_SLOT];
    logic [CNT_WIDTH-1:0] period_d [NUM_SLOT];

    rtc_sched_state_e     state_q, state_d;
    logic [IDX_WIDTH-1:0] evt_idx_q, evt_idx_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    logic [NUM_SLOT-1:0]  cfg_mask;
    logic [NUM_SLOT-1:0]  hs_clr;
    logic [NUM_SLOT-1:0]  arb_req;
    logic [IDX_WIDTH-1:0] arb_grant;
    logic                 arb_any;
    logic                 cancel;
    logic                 match;

    always_comb begin
        cfg_mask = '0;
        if (cfg_wr_i) begin
            cfg_mask[cfg_idx_i] = 1'b1;
        end
    end

    // A slot being rewritten this cycle must not be granted; its pend is about to clear.
    assign arb_req = pend_q & ~cfg_mask;
    assign cancel  = cfg_wr_i && (cfg_idx_i == evt_idx_q);

    rtc_rr_arb #(
        .NUM_SLOT  (NUM_SLOT),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        en_d     = en_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        alarm_d  = alarm_q;
        period_d = period_q;
        match    = 1'b0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            match = cnt_vld_i && en_q[i] && (cnt_i == alarm_q[i]);
            if (cfg_mask[i]) begin
                en_d[i]     = cfg_en_i;
                alarm_d[i]  = cfg_alarm_i;
                period_d[i] = cfg_period_i;
                pend_d[i]   = 1'b0;
                ovf_d[i]    = 1'b0;
            end else if (match) begin
                // A match landing on the handshake cycle replaces the event, not overruns it.
                pend_d[i] = 1'b1;
                if (pend_q[i] && !hs_clr[i]) begin
                    ovf_d[i] = 1'b1;
                end
                if (period_q[i] != '0) begin
                    alarm_d[i] = alarm_q[i] + period_q[i];
                end else begin
                    en_d[i] = 1'b0;
                end
            end else if (hs_clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_q   <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < NUM_SLOT; i++) begin
                alarm_q[i]  <= '0;
                period_q[i] <= '0;
            end
        end else begin
            en_q     <= en_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            alarm_q  <= alarm_d;
            period_q <= period_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            evt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            evt_idx_q <= evt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        evt_idx_d = evt_idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    evt_idx_d = arb_grant;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (evt_ready_i) begin
                    ptr_d   = (evt_idx_q == IDX_WIDTH'(NUM_SLOT - 1)) ? '0 : evt_idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_valid_o = (state_q == PRESENT);
        hs_clr      = '0;
        if ((state_q == PRESENT) && evt_ready_i && !cancel) begin
            hs_clr[evt_idx_q] = 1'b1;
        end
    end

    assign irq_o     = evt_valid_o;
    assign evt_idx_o = evt_idx_q;
    assign en_o      = en_q;
    assign pend_o    = pend_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// tb/tb_rtc_alarm_sched.sv - directed self-checking bench for rtc_alarm_sched
module tb_rtc_alarm_sched;

    localparam int NS = 4;
    localparam int CW = 32;
    localparam int IW = 2;

    logic          clk_i;
    logic          rst_n_i;
    logic [CW-1:0] cnt_i;
    logic          cnt_vld_i;
    logic          cfg_wr_i;
    logic [IW-1:0] cfg_idx_i;
    logic          cfg_en_i;
    logic [CW-1:0] cfg_alarm_i;
    logic [CW-1:0] cfg_period_i;
    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [IW-1:0] evt_idx_o;
    logic          irq_o;
    logic [NS-1:0] en_o;
    logic [NS-1:0] pend_o;
    logic [NS-1:0] ovf_o;

    int n_chk;
    int n_fail;

    rtc_alarm_sched #(
        .NUM_SLOT  (NS),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cnt_i        (cnt_i),
        .cnt_vld_i    (cnt_vld_i),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_alarm_i  (cfg_alarm_i),
        .cfg_period_i (cfg_period_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_idx_o    (evt_idx_o),
        .irq_o        (irq_o),
        .en_o         (en_o),
        .pend_o       (pend_o),
        .ovf_o        (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input int idx, input logic en, input logic [CW-1:0] alarm,
                       input logic [CW-1:0] period);
        cfg_wr_i     = 1'b1;
        cfg_idx_i    = IW'(idx);
        cfg_en_i     = en;
        cfg_alarm_i  = alarm;
        cfg_period_i = period;
        tick();
        cfg_wr_i = 1'b0;
    endtask

    task automatic pulse(input logic [CW-1:0] v);
        cnt_i     = v;
        cnt_vld_i = 1'b1;
        tick();
        cnt_vld_i = 1'b0;
    endtask

    task automatic accept(input string tag, input int exp_idx);
        int n;
        n = 0;
        while (!evt_valid_o && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(evt_valid_o), 64'd1);
        check({tag, "_idx"}, 64'(evt_idx_o), 64'(exp_idx));
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        check({tag, "_done"}, 64'(evt_valid_o), 64'd0);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
    endtask

    logic exp_v [7];
    int   exp_i [7];

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst_n_i      = 1'b0;
        cnt_i        = '0;
        cnt_vld_i    = 1'b0;
        cfg_wr_i     = 1'b0;
        cfg_idx_i    = '0;
        cfg_en_i     = 1'b0;
        cfg_alarm_i  = '0;
        cfg_period_i = '0;
        evt_ready_i  = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        check("rst_valid", 64'(evt_valid_o), 64'd0);
        check("rst_idx", 64'(evt_idx_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_en", 64'(en_o), 64'd0);
        check("rst_pend", 64'(pend_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);

        // One-shot slot 0 at count 5
        cfg(0, 1'b1, 32'd5, 32'd0);
        check("os_en_set", 64'(en_o), 64'h1);
        for (int c = 0; c < 5; c++) pulse(CW'(c));
        check("os_no_early", 64'(pend_o), 64'h0);
        pulse(32'd5);
        check("os_pend_c1", 64'(pend_o), 64'h1);
        check("os_valid_c1", 64'(evt_valid_o), 64'd0);
        check("os_en_clr", 64'(en_o), 64'h0);
        tick();
        check("os_valid_c2", 64'(evt_valid_o), 64'd1);
        check("os_irq_c2", 64'(irq_o), 64'd1);
        check("os_idx_c2", 64'(evt_idx_o), 64'd0);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        check("os_hs_valid", 64'(evt_valid_o), 64'd0);
        check("os_hs_pend", 64'(pend_o), 64'h0);
        pulse(32'd5);
        check("os_no_rematch", 64'(pend_o), 64'h0);

        // Periodic slot 1 wrapping past 2^32
        cfg(1, 1'b1, 32'hFFFF_FFFE, 32'd4);
        pulse(32'hFFFF_FFFE);
        check("per_pend_a", 64'(pend_o), 64'h2);
        accept("per_a", 1);
        pulse(32'd0);
        check("per_no_0", 64'(pend_o), 64'h0);
        pulse(32'd2);
        check("per_pend_b", 64'(pend_o), 64'h2);
        accept("per_b", 1);
        pulse(32'd6);
        check("per_pend_c", 64'(pend_o), 64'h2);
        accept("per_c", 1);
        check("per_en_kept", 64'(en_o), 64'h2);
        cfg(1, 1'b0, 32'd0, 32'd0);

        // Round-robin from ptr=0 with ready held high
        do_reset();
        cfg(0, 1'b1, 32'd10, 32'd0);
        cfg(2, 1'b1, 32'd10, 32'd0);
        cfg(3, 1'b1, 32'd10, 32'd0);
        evt_ready_i = 1'b1;
        pulse(32'd10);
        check("rr_pend", 64'(pend_o), 64'hD);
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_i = '{0, 0, 0, 2, 2, 3, 3};
        for (int k = 0; k < 7; k++) begin
            check($sformatf("rr_valid_%0d", k), 64'(evt_valid_o), 64'(exp_v[k]));
            if (exp_v[k]) check($sformatf("rr_idx_%0d", k), 64'(evt_idx_o), 64'(exp_i[k]));
            if (k < 6) tick();
        end
        check("rr_pend_done", 64'(pend_o), 64'h0);
        cfg(0, 1'b1, 32'd20, 32'd0);
        cfg(3, 1'b1, 32'd20, 32'd0);
        pulse(32'd20);
        check("rr2_pend", 64'(pend_o), 64'h9);
        tick();
        check("rr2_first", 64'(evt_idx_o), 64'd0);
        tick();
        check("rr2_gap", 64'(evt_valid_o), 64'd0);
        tick();
        check("rr2_second_v", 64'(evt_valid_o), 64'd1);
        check("rr2_second", 64'(evt_idx_o), 64'd3);
        tick();
        evt_ready_i = 1'b0;
        check("rr2_empty", 64'(pend_o), 64'h0);

        // Overrun on slot 2, then cancelling config write
        cfg(2, 1'b1, 32'd30, 32'd1);
        pulse(32'd30);
        check("ovf_pend", 64'(pend_o), 64'h4);
        check("ovf_not_yet", 64'(ovf_o), 64'h0);
        pulse(32'd31);
        pulse(32'd32);
        check("ovf_set", 64'(ovf_o), 64'h4);
        check("ovf_valid", 64'(evt_valid_o), 64'd1);
        check("ovf_idx", 64'(evt_idx_o), 64'd2);
        cfg(2, 1'b0, 32'd0, 32'd0);
        check("cancel_valid", 64'(evt_valid_o), 64'd0);
        check("cancel_pend", 64'(pend_o), 64'h0);
        check("cancel_ovf", 64'(ovf_o), 64'h0);

        // Handshake colliding with a new match of the same slot
        cfg(1, 1'b1, 32'd40, 32'd1);
        pulse(32'd40);
        tick();
        check("sim_valid", 64'(evt_valid_o), 64'd1);
        check("sim_idx", 64'(evt_idx_o), 64'd1);
        evt_ready_i = 1'b1;
        pulse(32'd41);
        evt_ready_i = 1'b0;
        check("sim_pend_kept", 64'(pend_o), 64'h2);
        check("sim_no_ovf", 64'(ovf_o), 64'h0);
        check("sim_gap", 64'(evt_valid_o), 64'd0);
        accept("sim_again", 1);
        cfg_wr_i     = 1'b1;
        cfg_idx_i    = 2'd1;
        cfg_en_i     = 1'b1;
        cfg_alarm_i  = 32'd100;
        cfg_period_i = 32'd0;
        cnt_i        = 32'd42;
        cnt_vld_i    = 1'b1;
        tick();
        cfg_wr_i  = 1'b0;
        cnt_vld_i = 1'b0;
        check("wr_wins_pend", 64'(pend_o), 64'h0);
        tick();
        check("wr_wins_valid", 64'(evt_valid_o), 64'd0);

        // Reset while presenting; ptr must return to 0 (ptr was 2 before)
        pulse(32'd100);
        tick();
        check("mid_valid", 64'(evt_valid_o), 64'd1);
        do_reset();
        check("mr_valid", 64'(evt_valid_o), 64'd0);
        check("mr_irq", 64'(irq_o), 64'd0);
        check("mr_idx", 64'(evt_idx_o), 64'd0);
        check("mr_en", 64'(en_o), 64'h0);
        check("mr_pend", 64'(pend_o), 64'h0);
        check("mr_ovf", 64'(ovf_o), 64'h0);
        cfg(3, 1'b1, 32'd200, 32'd0);
        cfg(0, 1'b1, 32'd200, 32'd0);
        pulse(32'd200);
        accept("mr_ptr0", 0);
        accept("mr_next", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
